// File: rtl/buffet_fill_pkg.sv
// Shared types and helpers for the buffet fill controller.
//   fill_state_e : fill FSM states
//   count_width  : bits needed to hold the values 0..max_val inclusive
package buffet_fill_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } fill_state_e;

    // Equivalent to clog2(max_val + 1), never less than 1.
    function automatic int unsigned count_width(input int unsigned max_val);
        longint unsigned lim;
        longint unsigned mv;
        int unsigned     w;
        lim = 2;
        mv  = longint'(max_val);
        w   = 1;
        while (lim <= mv) begin
            lim = lim * 2;
            w   = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/buffet_credit_counter.sv
// Local credit pool mirroring free buffet slots.
// Ports:
//   clk, reset_i : clock and synchronous active-high reset (count returns to SIZE)
//   add_amt      : number of slots returned by the buffet
//   add_valid    : add_amt is valid this cycle
//   take         : one slot reserved for an issued request
//   count        : current credit count, 0..SIZE
//   nonzero      : count != 0
//   overflow     : sticky, set when a return would push the pool above SIZE
module buffet_credit_counter
    import buffet_fill_pkg::*;
#(
    parameter int unsigned SIZE      = 256,
    parameter int unsigned IDX_WIDTH = 8,
    localparam int unsigned CntW     = count_width(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [IDX_WIDTH-1:0] add_amt,
    input  logic                 add_valid,
    input  logic                 take,
    output logic [CntW-1:0]      count,
    output logic                 nonzero,
    output logic                 overflow
);

    // One spare bit so count + add never wraps before the clamp compare.
    localparam int unsigned SumW = ((CntW > IDX_WIDTH) ? CntW : IDX_WIDTH) + 1;

    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [SumW-1:0] sum;
    logic            take_ok;

    // A take on an empty pool would wrap; the caller never does this.
    assign take_ok = take && (count_q != '0);

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        sum        = SumW'(count_q)
                   + (add_valid ? SumW'(add_amt) : SumW'(0))
                   - SumW'(take_ok);
        if (sum > SumW'(SIZE)) begin
            count_d    = CntW'(SIZE);
            overflow_d = 1'b1;
        end else begin
            count_d = sum[CntW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q    <= CntW'(SIZE);
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign nonzero  = (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/buffet_fill_ctrl.sv
// Buffet fill controller: turns a (base, length) fill command into in-order
// memory word reads and forwards the responses to the buffet push port.
// Every request first reserves a buffet slot from a local credit pool that the
// buffet replenishes, so pushes can never overrun buffet storage.
// Ports:
//   clk, reset_i                 : clock, synchronous active-high reset
//   cmd_addr/len/valid/ready     : fill command (word address, length in words)
//   mem_req_addr/valid/ready     : memory read request
//   mem_resp_data/valid/ready    : in-order memory read response
//   push_data/valid/ready        : buffet push port
//   credit_in/valid/ready        : freed slots returned by the buffet
//   busy                         : a command is in progress
//   done                         : one-cycle pulse at command completion
//   credit_err                   : sticky, credit pool overflowed
module buffet_fill_ctrl
    import buffet_fill_pkg::*;
#(
    parameter int unsigned IDX_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned SIZE            = 256,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_data_valid,
    input  logic                  push_data_ready,
    input  logic [IDX_WIDTH-1:0]  credit_in,
    input  logic                  credit_in_valid,
    output logic                  credit_in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  credit_err
);

    localparam int unsigned CntW = count_width(SIZE);
    localparam int unsigned OutW = count_width(MAX_OUTSTANDING);

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [OutW-1:0]       outstanding_q, outstanding_d;
    logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
    logic                  push_valid_q, push_valid_d;

    logic [CntW-1:0]       credit_cnt;
    logic                  credit_nonzero;
    logic                  req_fire;
    logic                  resp_fire;
    logic                  resp_load;
    logic                  push_fire;

    buffet_credit_counter #(
        .SIZE      (SIZE),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_credit (
        .clk       (clk),
        .reset_i   (reset_i),
        .add_amt   (credit_in),
        .add_valid (credit_in_valid && credit_in_ready),
        .take      (req_fire),
        .count     (credit_cnt),
        .nonzero   (credit_nonzero),
        .overflow  (credit_err)
    );

    assign credit_in_ready = 1'b1;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign push_fire = push_valid_q && push_data_ready;
    assign resp_fire = mem_resp_valid && mem_resp_ready;
    // Responses while idle are accepted but dropped: nothing asked for them.
    assign resp_load = resp_fire && (state_q != StIdle);

    // The output register can take a new word whenever it is empty or draining.
    assign mem_resp_ready  = !push_valid_q || push_data_ready;
    assign push_data       = push_data_q;
    assign push_data_valid = push_valid_q;
    assign mem_req_addr    = cur_addr_q;

    // Fill FSM; mem_req_valid is a function of registered state only.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = (cmd_len == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                mem_req_valid = (remaining_q != '0) && credit_nonzero
                             && (outstanding_q < OutW'(MAX_OUTSTANDING));
                if (mem_req_valid && mem_req_ready) begin
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((outstanding_q == '0) && !push_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outstanding spans issue to push, so it also covers the output register.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !push_fire) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!req_fire && push_fire) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_comb begin
        push_data_d  = push_data_q;
        push_valid_d = push_valid_q;
        if (resp_load) begin
            push_data_d  = mem_resp_data;
            push_valid_d = 1'b1;
        end else if (push_fire) begin
            push_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= StIdle;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            push_data_q   <= '0;
            push_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            push_data_q   <= push_data_d;
            push_valid_q  <= push_valid_d;
        end
    end

    credit_in_range: assert property (@(posedge clk) disable iff (reset_i)
        credit_cnt <= CntW'(SIZE));

    outstanding_in_range: assert property (@(posedge clk) disable iff (reset_i)
        outstanding_q <= OutW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_buffet_fill_ctrl.sv
module tb_buffet_fill_ctrl;

    localparam int unsigned IdxW   = 8;
    localparam int unsigned DataW  = 32;
    localparam int unsigned AddrW  = 16;
    localparam int unsigned LenW   = 8;
    localparam int unsigned Size   = 4;
    localparam int unsigned MaxOut = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_i;
    logic [AddrW-1:0] cmd_addr;
    logic [LenW-1:0]  cmd_len;
    logic             cmd_valid, cmd_ready;
    logic [AddrW-1:0] mem_req_addr;
    logic             mem_req_valid, mem_req_ready;
    logic [DataW-1:0] mem_resp_data;
    logic             mem_resp_valid, mem_resp_ready;
    logic [DataW-1:0] push_data;
    logic             push_data_valid, push_data_ready;
    logic [IdxW-1:0]  credit_in;
    logic             credit_in_valid, credit_in_ready;
    logic             busy, done, credit_err;

    buffet_fill_ctrl #(
        .IDX_WIDTH       (IdxW),
        .DATA_WIDTH      (DataW),
        .ADDR_WIDTH      (AddrW),
        .LEN_WIDTH       (LenW),
        .SIZE            (Size),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_data   (mem_resp_data),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_ready  (mem_resp_ready),
        .push_data       (push_data),
        .push_data_valid (push_data_valid),
        .push_data_ready (push_data_ready),
        .credit_in       (credit_in),
        .credit_in_valid (credit_in_valid),
        .credit_in_ready (credit_in_ready),
        .busy            (busy),
        .done            (done),
        .credit_err      (credit_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               cred;         // free buffet slots as seen by the controller
    bit               cred_err_m;
    int               outst;        // issued but not yet pushed
    logic [DataW-1:0] mem_q[$];     // accepted requests awaiting a response
    logic [AddrW-1:0] exp_addr_q[$];
    logic [DataW-1:0] exp_push_q[$];
    int               pend_credit;  // pushed words the consumer has not yet returned
    int n_req, n_push, n_done, n_valid_cycles, n_rdy_low;
    bit               prev_stall, prev_cmd_fire, prev_done, resp_fired, ret_auto;
    logic [DataW-1:0] prev_data;

    // stimulus policy
    int rdy_pct, resp_pct, mreq_pct;
    bit auto_credit, arm_edge;
    int one_credit;

    function automatic logic [DataW-1:0] word_of(input logic [AddrW-1:0] a);
        return {a, ~a} ^ 32'h5A3C_0F96;
    endfunction

    task automatic clear_model();
        cred = Size; cred_err_m = 0; outst = 0; pend_credit = 0;
        mem_q.delete(); exp_addr_q.delete(); exp_push_q.delete();
        prev_stall = 0; prev_cmd_fire = 0; prev_done = 0; resp_fired = 0;
        arm_edge = 0; one_credit = 0;
    endtask

    task automatic observe();
        check("credit_err", credit_err, cred_err_m);
        if (prev_cmd_fire) check("busy_after_cmd", busy, 1);
        if (prev_done) begin
            check("busy_after_done", busy, 0);
            check("cmd_ready_after_done", cmd_ready, 1);
        end
        if (prev_stall) check("push_hold", {push_data_valid, push_data}, {1'b1, prev_data});
        if (mem_req_valid) n_valid_cycles++;
        if (!cmd_ready) n_rdy_low++;
        if (done) n_done++;
        if (cmd_valid && cmd_ready) begin
            for (int i = 0; i < int'(cmd_len); i++) begin
                logic [AddrW-1:0] a;
                a = cmd_addr + AddrW'(i);
                exp_addr_q.push_back(a);
                exp_push_q.push_back(word_of(a));
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            n_req++;
            check("req_has_credit", cred > 0, 1);
            check("req_outstanding", outst < int'(MaxOut), 1);
            if (exp_addr_q.size() == 0) check("req_unexpected", 1, 0);
            else check("req_addr", mem_req_addr, exp_addr_q.pop_front());
            mem_q.push_back(word_of(mem_req_addr));
            outst++;
            cred--;
        end
        resp_fired = mem_resp_valid && mem_resp_ready;
        if (resp_fired && mem_q.size() != 0) void'(mem_q.pop_front());
        if (push_data_valid && push_data_ready) begin
            n_push++;
            outst--;
            pend_credit++;
            if (exp_push_q.size() == 0) check("push_unexpected", 1, 0);
            else check("push_data", push_data, exp_push_q.pop_front());
        end
        if (credit_in_valid && credit_in_ready) begin
            cred += int'(credit_in);
            if (ret_auto) pend_credit -= int'(credit_in);
        end
        if (cred > int'(Size)) begin
            cred = Size;
            cred_err_m = 1;
        end
        prev_stall    = push_data_valid && !push_data_ready;
        prev_data     = push_data;
        prev_cmd_fire = cmd_valid && cmd_ready;
        prev_done     = done;
    endtask

    task automatic drive();
        mem_req_ready   = int'($urandom_range(99)) < mreq_pct;
        push_data_ready = int'($urandom_range(99)) < rdy_pct;
        if (mem_resp_valid && !resp_fired) begin
            // hold the offered response until it is taken
        end else if (mem_q.size() != 0 && int'($urandom_range(99)) < resp_pct) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q[0];
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom();
        end
        credit_in_valid = 1'b0;
        credit_in       = '0;
        ret_auto        = 0;
        if (one_credit != 0) begin
            credit_in_valid = 1'b1;
            credit_in       = IdxW'(one_credit);
            one_credit      = 0;
        end else if (arm_edge && cred == 1 && mem_req_valid && mem_req_ready) begin
            credit_in_valid = 1'b1;
            credit_in       = IdxW'(1);
            arm_edge        = 0;
        end else if (auto_credit && pend_credit > 0 && $urandom_range(1) == 1) begin
            credit_in_valid = 1'b1;
            credit_in       = IdxW'((pend_credit > 255) ? 255 : pend_credit);
            ret_auto        = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!reset_i) observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset_i = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        push_data_ready = 1'b0; credit_in_valid = 1'b0; credit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        clear_model();
    endtask

    task automatic start_cmd(input logic [AddrW-1:0] a, input logic [LenW-1:0] l);
        int cyc = 0;
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        do begin
            step();
            cyc++;
        end while (!prev_cmd_fire && cyc < 200);
        cmd_valid = 1'b0;
        check("cmd_accepted", prev_cmd_fire, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0  = n_done;
        int cyc = 0;
        while (n_done == d0 && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_done_seen"}, n_done != d0, 1);
    endtask

    task automatic run_cmd(input logic [AddrW-1:0] a, input logic [LenW-1:0] l,
                           input int budget);
        int r0 = n_req, p0 = n_push, d0 = n_done;
        start_cmd(a, l);
        wait_done("cmd", budget);
        step();
        check("req_count", n_req - r0, l);
        check("push_count", n_push - p0, l);
        check("done_pulses", n_done - d0, 1);
    endtask

    typedef struct {
        logic [AddrW-1:0] addr;
        logic [LenW-1:0]  len;
        int               rdy;
        int               resp;
        int               mreq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, p0, v0, l0;
        vecs[0] = '{16'h0100, 8'd4,  100, 100, 100};
        vecs[1] = '{16'hFFFE, 8'd5,  100, 100, 100};
        vecs[2] = '{16'h0040, 8'd1,  100, 100, 100};
        vecs[3] = '{16'h1234, 8'd9,  50,  60,  70};
        vecs[4] = '{16'h2000, 8'd12, 30,  100, 100};
        vecs[5] = '{16'h0000, 8'd3,  100, 40,  50};
        n_req = 0; n_push = 0; n_done = 0; n_valid_cycles = 0; n_rdy_low = 0;
        rdy_pct = 100; resp_pct = 100; mreq_pct = 100; auto_credit = 1;

        // reset values
        do_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_credit_in_ready", credit_in_ready, 1);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_push_valid", push_data_valid, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_push_data", push_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_credit_err", credit_err, 0);

        // table-driven fills
        for (int i = 0; i < 6; i++) begin
            rdy_pct = vecs[i].rdy; resp_pct = vecs[i].resp; mreq_pct = vecs[i].mreq;
            run_cmd(vecs[i].addr, vecs[i].len, 600);
        end

        // zero length
        rdy_pct = 100; resp_pct = 100; mreq_pct = 100;
        v0 = n_valid_cycles; l0 = n_rdy_low;
        run_cmd(16'h0055, 8'd0, 20);
        check("zl_no_req_valid", n_valid_cycles - v0, 0);
        check("zl_rdy_low_cycles", n_rdy_low - l0, 1);

        // randomized commands
        for (int i = 0; i < 30; i++) begin
            rdy_pct  = 30 + int'($urandom_range(70));
            resp_pct = 30 + int'($urandom_range(70));
            mreq_pct = 20 + int'($urandom_range(80));
            run_cmd(AddrW'($urandom()), LenW'($urandom_range(10)), 800);
        end
        rdy_pct = 100; resp_pct = 100; mreq_pct = 100;

        // credit starvation
        do_reset();
        auto_credit = 0;
        r0 = n_req;
        start_cmd(16'h0800, 8'd6);
        repeat (30) step();
        check("starve_req_count", n_req - r0, Size);
        check("starve_req_valid", mem_req_valid, 0);
        check("starve_busy", busy, 1);
        one_credit = 2;
        wait_done("starve", 100);
        check("starve_req_total", n_req - r0, 6);

        // credit return in the same cycle as the issue at credit 1
        do_reset();
        r0 = n_req;
        arm_edge = 1;
        start_cmd(16'h0900, 8'd6);
        repeat (40) step();
        check("edge_req_count", n_req - r0, 5);
        check("edge_req_valid", mem_req_valid, 0);
        one_credit = 1;
        wait_done("edge", 100);
        check("edge_req_total", n_req - r0, 6);

        // overflow clamps to SIZE and sets credit_err
        do_reset();
        run_cmd(16'h0A00, 8'd1, 100);
        one_credit = 3;
        repeat (3) step();
        check("clamp_err", credit_err, 1);
        r0 = n_req;
        start_cmd(16'h0B00, 8'd6);
        repeat (20) step();
        check("clamp_req_count", n_req - r0, Size);
        do_reset();
        check("clamp_err_cleared", credit_err, 0);

        // push backpressure
        auto_credit = 1; rdy_pct = 0;
        r0 = n_req; p0 = n_push;
        start_cmd(16'h0300, 8'd8);
        repeat (10) step();
        check("bp_req_cap", n_req - r0, MaxOut);
        check("bp_no_push", n_push - p0, 0);
        check("bp_push_valid", push_data_valid, 1);
        check("bp_req_valid", mem_req_valid, 0);
        rdy_pct = 100;
        wait_done("bp", 400);
        step();
        check("bp_req_total", n_req - r0, 8);
        check("bp_push_total", n_push - p0, 8);

        // reset in the middle of a command
        rdy_pct = 0;
        r0 = n_req;
        start_cmd(16'h0400, 8'd8);
        repeat (6) step();
        check("mid_outstanding", n_req - r0, MaxOut);
        reset_i = 1'b1; mem_resp_valid = 1'b0; credit_in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        clear_model();
        rdy_pct = 100;
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_req_valid", mem_req_valid, 0);
        check("mid_push_valid", push_data_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_req_addr", mem_req_addr, 0);
        auto_credit = 0;
        r0 = n_req;
        start_cmd(16'h0500, 8'd6);
        repeat (20) step();
        check("mid_credit_full", n_req - r0, Size);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
